wb_stage_v2: RTL
================

Name: wb_stage_v2

Overview:
- Second-generation writeback stage: adds a load-response handshake, byte-lane load alignment (LB/LBU/LH/LHU/LW/LWL/LWR), a buffer for responses that arrive while stalled, and a load timeout.
- Sits between the MEM/WB pipeline register and the regfile/hilo; drives wb_stallreq to the controller while a load is outstanding.
- Produces the debug commit trace.

Parameters:
- MAX_WAIT, 15, cycles in WAIT before a load is abandoned (1..255).
- CNT_W, 8, width of the wait counter; MAX_WAIT must be less than 2^CNT_W.
- MOP_W, 4, width of the memop field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_stall_i  in  1  downstream freeze; no commit while high
- wb_flush_i  in  1  kill current instruction
- wb_valid_i  in  1  instruction present in stage
- wb_memop_i  in  MOP_W  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=LWL, 7=LWR; others treated as none
- wb_wren_i  in  4  byte write enables for non-load ops
- wb_waddr_i  in  5  dest reg
- wb_wdata_i  in  32  ALU result, or old rt value for LWL/LWR merge
- wb_pc_i  in  32  pc
- wb_mem_addr_i  in  32  load address; only [1:0] used
- wb_mem_rdata_i  in  32  load response word
- wb_mem_rvalid_i  in  1  response valid, single-cycle pulse
- wb_hi_i, wb_lo_i  in  32  hi/lo values
- wb_whien_i, wb_wloen_i  in  1  hi/lo write enables
- wb_inst_mfhi_i, wb_inst_mflo_i  in  1  select hi/lo as wdata
- wb_wren_o  out  4  regfile byte enables
- wb_waddr_o  out  5  regfile dest
- wb_wdata_o  out  32  regfile data
- wb_whien_o, wb_wloen_o  out  1  hi/lo enables (gated)
- wb_hi_o, wb_lo_o  out  32  hi/lo data
- wb_stallreq  out  1  stall request to controller
- wb_timeout_o  out  1  one-cycle pulse when a load is abandoned
- debug_wb_pc  out  32  committed pc, 0 if none
- debug_wb_rf_wen  out  4  committed byte enables, 0 if none
- debug_wb_rf_wnum  out  5  committed dest, 0 if none
- debug_wb_rf_wdata  out  32  committed data, 0 if none

Behaviour:
- Inputs are held stable by upstream while wb_stallreq or wb_stall_i is high.
- "is_load" = wb_valid_i and memop is in 1..7.
- State IDLE/WAIT; cnt (CNT_W bits); buffer buf_data (32) and buf_full (1).
- Reset: state=IDLE, cnt=0, buf_full=0, buf_data=0. All outputs are 0, wb_stallreq=0.
- data_avail = wb_mem_rvalid_i or buf_full. rd = buf_full ? buf_data : wb_mem_rdata_i.
- If wb_mem_rvalid_i and buf_full are both high, the buffered word wins and the new response is dropped.
- IDLE, is_load, not data_avail: wb_stallreq=1, go to WAIT, cnt=0.
- IDLE, is_load, data_avail: a commit is possible in the same cycle (0-cycle latency).
- WAIT, not data_avail: wb_stallreq=1 and cnt++.
  - When cnt==MAX_WAIT: wb_timeout_o=1 for one cycle, no commit, wb_stallreq=0, go to IDLE, cnt=0.
- WAIT, data_avail: commit is possible, wb_stallreq=0, go to IDLE.
- commit = wb_valid_i and not wb_stall_i and not wb_flush_i, and (not is_load or data_avail), and not timeout.
- Stall with data pending: if wb_stall_i=1 and wb_mem_rvalid_i=1, latch buf_data=rdata and buf_full=1.
  - While wb_stall_i is high, state and cnt hold. wb_stallreq is still asserted in WAIT while no data is available.
- buf_full clears on a load commit, on flush, and on timeout.
- wb_flush_i (highest priority after rst): state=IDLE, cnt=0, buf_full=0, no commit, wb_stallreq=0, wb_timeout_o=0.
- Load alignment, a = mem_addr[1:0]:
  - LB/LBU: byte a, sign- or zero-extended; wren=1111.
  - LH/LHU: halfword a[1]; a[0] is ignored; sign- or zero-extended; wren=1111.
  - LW: rd; wren=1111.
  - LWL: new = rd << 8*(3-a); wren = 1111 << (3-a), truncated to 4 bits.
  - LWR: new = rd >> 8*a; wren = 1111 >> a.
  - LWL/LWR: wdata_o takes bytes from new where wren is set and from wb_wdata_i elsewhere.
- Non-load: wdata = mfhi ? hi : mflo ? lo : wb_wdata_i. wren = wb_wren_i.
- Gated by commit:
  - wb_wren_o, and the debug wen/wnum/wdata/pc, are 0 when commit=0.
  - wb_whien_o and wb_wloen_o are 0 when commit=0.
  - wb_waddr_o, wb_wdata_o, wb_hi_o and wb_lo_o pass ungated.
- wb_timeout_o is combinational in the expiry cycle; it is never asserted together with commit.

Test Plan:
- Reset held 2 cycles, then released with valid=0 -> all outputs 0, stallreq=0.
- LW at addr 0x..0, rvalid in same cycle with rdata=0x8899AABB -> wren=1111, wdata=0x8899AABB, stallreq=0 throughout.
- LB at addr 0x..2, rdata=0x11F02233, rvalid after 3 cycles -> stallreq high exactly 3 cycles, then commit wdata=0xFFFFFFF0; LBU of the same -> 0x000000F0.
- LWL at a=1, old rt=0xAABBCCDD, rdata=0x44332211 -> wren=1100, wdata=0x2211CCDD. LWR at a=2, same inputs -> wren=0011, wdata=0xAABB4433.
- rvalid arrives while wb_stall_i=1 with rdata=0x12345678; stall drops 2 cycles later -> commit 0x12345678 with no second rvalid; buf_full cleared.
- Load with no response, MAX_WAIT=15 -> stallreq high for 16 cycles, wb_timeout_o pulses once, no commit. Separately, flush in WAIT -> IDLE next cycle, no commit, stallreq=0.

Source files
------------

// File: rtl/wb_stage_v2_if.sv
// Interface for the writeback stage. It bundles the MEM/WB pipeline-register
// fields, the load response, and the regfile/hilo write port.
interface wb_stage_v2_if #(
  parameter int MOP_W = 4
);
  logic             wb_valid_i;
  logic [MOP_W-1:0] wb_memop_i;
  logic [3:0]       wb_wren_i;
  logic [4:0]       wb_waddr_i;
  logic [31:0]      wb_wdata_i;
  logic [31:0]      wb_pc_i;
  logic [31:0]      wb_mem_addr_i;
  logic [31:0]      wb_mem_rdata_i;
  logic             wb_mem_rvalid_i;
  logic [31:0]      wb_hi_i;
  logic [31:0]      wb_lo_i;
  logic             wb_whien_i;
  logic             wb_wloen_i;
  logic             wb_inst_mfhi_i;
  logic             wb_inst_mflo_i;

  logic [3:0]       wb_wren_o;
  logic [4:0]       wb_waddr_o;
  logic [31:0]      wb_wdata_o;
  logic             wb_whien_o;
  logic             wb_wloen_o;
  logic [31:0]      wb_hi_o;
  logic [31:0]      wb_lo_o;

  modport master (
    output wb_valid_i, wb_memop_i, wb_wren_i, wb_waddr_i, wb_wdata_i, wb_pc_i,
           wb_mem_addr_i, wb_mem_rdata_i, wb_mem_rvalid_i, wb_hi_i, wb_lo_i,
           wb_whien_i, wb_wloen_i, wb_inst_mfhi_i, wb_inst_mflo_i,
    input  wb_wren_o, wb_waddr_o, wb_wdata_o, wb_whien_o, wb_wloen_o,
           wb_hi_o, wb_lo_o
  );

  modport slave (
    input  wb_valid_i, wb_memop_i, wb_wren_i, wb_waddr_i, wb_wdata_i, wb_pc_i,
           wb_mem_addr_i, wb_mem_rdata_i, wb_mem_rvalid_i, wb_hi_i, wb_lo_i,
           wb_whien_i, wb_wloen_i, wb_inst_mfhi_i, wb_inst_mflo_i,
    output wb_wren_o, wb_waddr_o, wb_wdata_o, wb_whien_o, wb_wloen_o,
           wb_hi_o, wb_lo_o
  );
endinterface

// File: rtl/wb_stage_v2.sv
// Writeback stage. It handles the load-response handshake, byte-lane load
// alignment, a one-word buffer for responses that arrive while stalled, and a
// load timeout. It also drives the debug commit trace.
module wb_stage_v2 #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8,
  parameter int MOP_W    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_stall_i,
  input  logic         wb_flush_i,
  wb_stage_v2_if.slave bus,
  output logic         wb_stallreq,
  output logic         wb_timeout_o,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_wen,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_LW  = 3'd5;
  localparam logic [2:0] OP_LWL = 3'd6;
  localparam logic [2:0] OP_LWR = 3'd7;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              buf_full_q, buf_full_d;
  logic [31:0]       buf_data_q, buf_data_d;

  logic              is_load_s;
  logic              data_avail_s;
  logic [31:0]       rd_s;
  logic [2:0]        op_s;
  logic              stallreq_s;
  logic              timeout_s;
  logic              commit_s;
  logic [35:0]       align_s;
  logic [3:0]        wren_s;
  logic [31:0]       wdata_s;

  // Returns {byte enables, data}. LWL/LWR keep the old rt bytes in the lanes
  // they do not write.
  function automatic logic [35:0] load_align(
    input logic [2:0]  op,
    input logic [1:0]  a,
    input logic [31:0] rd,
    input logic [31:0] old
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] new_v;
    logic [31:0] res_v;
    logic [3:0]  en_v;
    byte_v = rd[{a, 3'b000} +: 8];
    half_v = a[1] ? rd[31:16] : rd[15:0];
    new_v  = 32'h0000_0000;
    en_v   = 4'hF;
    res_v  = rd;
    case (op)
      OP_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  res_v = {24'h00_0000, byte_v};
      OP_LH:   res_v = {{16{half_v[15]}}, half_v};
      OP_LHU:  res_v = {16'h0000, half_v};
      OP_LW:   res_v = rd;
      OP_LWL: begin
        new_v = rd << {~a, 3'b000};
        en_v  = 4'hF << (~a);
        for (int i = 0; i < 4; i++) begin
          res_v[8*i +: 8] = en_v[i] ? new_v[8*i +: 8] : old[8*i +: 8];
        end
      end
      OP_LWR: begin
        new_v = rd >> {a, 3'b000};
        en_v  = 4'hF >> a;
        for (int i = 0; i < 4; i++) begin
          res_v[8*i +: 8] = en_v[i] ? new_v[8*i +: 8] : old[8*i +: 8];
        end
      end
      default: res_v = rd;
    endcase
    return {en_v, res_v};
  endfunction

  assign op_s         = bus.wb_memop_i[2:0];
  assign is_load_s    = bus.wb_valid_i && (bus.wb_memop_i >= MOP_W'(1)) &&
                        (bus.wb_memop_i <= MOP_W'(7));
  assign data_avail_s = bus.wb_mem_rvalid_i || buf_full_q;
  // A buffered word always wins over a fresh response.
  assign rd_s         = buf_full_q ? buf_data_q : bus.wb_mem_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      buf_full_q <= 1'b0;
      buf_data_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    stallreq_s = 1'b0;
    timeout_s  = 1'b0;
    commit_s   = 1'b0;
    if (wb_flush_i) begin
      state_d    = ST_IDLE;
      cnt_d      = {CNT_W{1'b0}};
      buf_full_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_load_s && !data_avail_s) begin
            stallreq_s = 1'b1;
            if (!wb_stall_i) begin
              state_d = ST_WAIT;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (data_avail_s) begin
            if (!wb_stall_i) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (wb_stall_i) begin
            // A frozen pipeline also freezes the timeout.
            stallreq_s = 1'b1;
          end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
            timeout_s = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = {CNT_W{1'b0}};
          end else begin
            stallreq_s = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase

      commit_s = bus.wb_valid_i && !wb_stall_i && (!is_load_s || data_avail_s) &&
                 !timeout_s;

      if (wb_stall_i && bus.wb_mem_rvalid_i && !buf_full_q) begin
        buf_full_d = 1'b1;
        buf_data_d = bus.wb_mem_rdata_i;
      end else if ((commit_s && is_load_s) || timeout_s) begin
        buf_full_d = 1'b0;
      end else begin
        buf_full_d = buf_full_q;
      end
    end
  end

  always_comb begin
    align_s = load_align(op_s, bus.wb_mem_addr_i[1:0], rd_s, bus.wb_wdata_i);
    if (is_load_s) begin
      wren_s  = align_s[35:32];
      wdata_s = align_s[31:0];
    end else begin
      wren_s = bus.wb_wren_i;
      if (bus.wb_inst_mfhi_i) begin
        wdata_s = bus.wb_hi_i;
      end else if (bus.wb_inst_mflo_i) begin
        wdata_s = bus.wb_lo_i;
      end else begin
        wdata_s = bus.wb_wdata_i;
      end
    end
  end

  // While reset is held, every output is forced to 0.
  always_comb begin
    wb_stallreq       = 1'b0;
    wb_timeout_o      = 1'b0;
    bus.wb_wren_o     = 4'h0;
    bus.wb_waddr_o    = 5'd0;
    bus.wb_wdata_o    = 32'h0000_0000;
    bus.wb_whien_o    = 1'b0;
    bus.wb_wloen_o    = 1'b0;
    bus.wb_hi_o       = 32'h0000_0000;
    bus.wb_lo_o       = 32'h0000_0000;
    debug_wb_pc       = 32'h0000_0000;
    debug_wb_rf_wen   = 4'h0;
    debug_wb_rf_wnum  = 5'd0;
    debug_wb_rf_wdata = 32'h0000_0000;
    if (!rst) begin
      wb_stallreq    = stallreq_s;
      wb_timeout_o   = timeout_s;
      bus.wb_waddr_o = bus.wb_waddr_i;
      bus.wb_wdata_o = wdata_s;
      bus.wb_hi_o    = bus.wb_hi_i;
      bus.wb_lo_o    = bus.wb_lo_i;
      if (commit_s) begin
        bus.wb_wren_o     = wren_s;
        bus.wb_whien_o    = bus.wb_whien_i;
        bus.wb_wloen_o    = bus.wb_wloen_i;
        debug_wb_pc       = bus.wb_pc_i;
        debug_wb_rf_wen   = wren_s;
        debug_wb_rf_wnum  = bus.wb_waddr_i;
        debug_wb_rf_wdata = wdata_s;
      end else begin
        bus.wb_wren_o = 4'h0;
      end
    end else begin
      wb_stallreq = 1'b0;
    end
  end

endmodule
